// File: rtl/adder_pkg.sv
// adder_pkg
//   Shared definitions for the shared-adder arbiter slice.
//   WIDTH     : operand width of the shared Brent_Kung adder.
//   state_e   : sequencer states (IDLE -> EXEC -> RESP).
//   id_width(): requester-ID width for a given requester count.
package adder_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // A single requester still needs a 1-bit ID field.
    function automatic int id_width(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if
//   Request and response channels of the shared adder.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         : per-requester operands, requester k in [k]
//   rsp_valid/rsp_ready : single response handshake
//   rsp_sum/rsp_carry   : WIDTH+1 bit result
//   rsp_id              : requester the result belongs to
//   master = requesters + response consumer, slave = arbiter.
interface adder_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0][WIDTH-1:0] req_a;
    logic [N_REQ-1:0][WIDTH-1:0] req_b;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [WIDTH-1:0]            rsp_sum;
    logic                        rsp_carry;
    logic [ID_W-1:0]             rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
    );
endinterface

// File: rtl/brent_kung.sv
// Brent_Kung
//   Combinational WIDTH-bit Brent-Kung prefix adder (WIDTH a power of two).
//   a, b  : operands
//   s     : sum
//   carry : carry-out
module Brent_Kung #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             carry
);
    localparam int LVL = $clog2(WIDTH);

    logic [WIDTH-1:0] g0, p0, gpre;

    // Up-sweep builds group generate/propagate at positions 2^(l+1)-1 mod
    // 2^(l+1); down-sweep fills the remaining positions from those anchors.
    // Updates are in place: within one level no merge target is also a
    // merge source, so the ordering inside a level does not matter.
    function automatic logic [WIDTH-1:0] prefix(input logic [WIDTH-1:0] gi,
                                                 input logic [WIDTH-1:0] pi);
        logic [WIDTH-1:0] g, p;
        g = gi;
        p = pi;
        for (int l = 0; l < LVL; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    g[i] = g[i] | (p[i] & g[i-(1<<l)]);
                    p[i] = p[i] & p[i-(1<<l)];
                end
            end
        end
        // Down-sweep sources already hold full prefixes, so only g is needed.
        for (int l = LVL - 2; l >= 0; l--) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
                    g[i] = g[i] | (p[i] & g[i-(1<<l)]);
                end
            end
        end
        return g;
    endfunction

    assign g0    = a & b;
    assign p0    = a ^ b;
    assign gpre  = prefix(g0, p0);
    assign s     = p0 ^ {gpre[WIDTH-2:0], 1'b0};
    assign carry = gpre[WIDTH-1];

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick. Search starts one past last_grant and
//   wraps modulo N_REQ.
//   req        : request vector
//   last_grant : index granted on the previous accept
//   gnt        : one-hot grant (zero when no request)
//   gnt_idx    : encoded grant index
//   found      : any request present
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             found
);
    logic [ID_W-1:0] idx;

    function automatic logic [ID_W-1:0] wrap(input logic [ID_W-1:0] base,
                                             input int off);
        return ID_W'((int'(base) + off) % N_REQ);
    endfunction

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        // Offset N_REQ lands back on last_grant: it is lowest priority.
        for (int k = 1; k <= N_REQ; k++) begin
            idx = wrap(last_grant, k);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (found) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Shares one Brent_Kung adder among N_REQ requesters. One transaction is
//   in flight at a time: accept (IDLE) -> add (EXEC) -> hold result (RESP).
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of adder_share_arbiter_if (requests in, response out)
module adder_share_arbiter
    import adder_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = adder_pkg::WIDTH,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_arbiter_if.slave bus
);
    state_e           state_q, state_d;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             found;
    logic             accept;

    logic [ID_W-1:0]  last_grant;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] add_s;
    logic             add_c;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [ID_W-1:0]  id_q;

    logic [N_REQ-1:0] req_ready_c;
    logic             rsp_valid_c;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .found      (found)
    );

    // Operands come from registers and the result lands in registers, so
    // the adder gets a full cycle regardless of requester-side timing.
    Brent_Kung #(
        .WIDTH (WIDTH)
    ) u_add (
        .a     (op_a),
        .b     (op_b),
        .s     (add_s),
        .carry (add_c)
    );

    assign accept = (state_q == IDLE) && found;

    always_comb begin
        state_d     = state_q;
        req_ready_c = '0;
        rsp_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_c = gnt;
                if (found) state_d = EXEC;
            end
            EXEC: state_d = RESP;
            RESP: begin
                rsp_valid_c = 1'b1;
                // Handshake returns to IDLE; next accept is a cycle later.
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            id_q       <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a       <= bus.req_a[gnt_idx];
                op_b       <= bus.req_b[gnt_idx];
                id_q       <= gnt_idx;
                last_grant <= gnt_idx;
            end
            if (state_q == EXEC) begin
                sum_q   <= add_s;
                carry_q <= add_c;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_carry = carry_q;
    assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter
//   Table of directed vectors, reset-during-EXEC sequence, a 2500-pair sweep
//   through requester 1 and randomized traffic against a round-robin model.
module tb_adder_share_arbiter;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_share_arbiter_if #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();

    adder_share_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int model_last;

    typedef struct {
        logic            rst;
        logic [3:0]      mask;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        int              stall;
        int              exp_id;
        logic [16:0]     exp_res;
    } vec_t;

    vec_t tbl[8];

    function automatic vec_t mk(input logic r, input logic [3:0] m,
                                input logic [63:0] a, input logic [63:0] b,
                                input int st, input int id, input logic [16:0] res);
        vec_t v;
        v.rst = r; v.mask = m; v.a = a; v.b = b;
        v.stall = st; v.exp_id = id; v.exp_res = res;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Round-robin reference: first valid index after the last grant, wrapping.
    function automatic int model_pick(input logic [3:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = N - 1;
    endtask

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic txn(input logic [3:0] m, input logic [3:0][15:0] a,
                       input logic [3:0][15:0] b, input int stall, input int eid,
                       input logic [16:0] eres, input string tag);
        bus.req_valid = m;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = 1'b0;
        #1;
        chk({tag, " grant"}, 32'(bus.req_ready), 32'(4'b0001 << eid));
        @(posedge clk);
        model_last = eid;
        @(negedge clk);
        chk({tag, " exec valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, " exec ready"}, 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk({tag, " rsp valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, " rsp result"}, 32'({bus.rsp_carry, bus.rsp_sum}), 32'(eres));
        chk({tag, " rsp id"}, 32'(bus.rsp_id), 32'(eid));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, " stall valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, " stall result"}, 32'({bus.rsp_carry, bus.rsp_sum}), 32'(eres));
            chk({tag, " stall id"}, 32'(bus.rsp_id), 32'(eid));
            chk({tag, " stall ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, " post handshake valid"}, 32'(bus.rsp_valid), 32'd0);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] va, vb;
        logic [3:0][15:0] ra, rb;
        logic [3:0] m;
        int pick;
        int bb;

        va = {16'hFFF0, 16'd1234, 16'h8000, 16'd100};
        vb = {16'h0020, 16'd4321, 16'h8000, 16'd200};
        tbl[0] = mk(1'b1, 4'b0001, {48'd0, 16'd75}, {48'd0, 16'd50}, 0, 0, 17'd125);
        tbl[1] = mk(1'b0, 4'b0100, {16'd0, 16'hFFFF, 32'd0}, {16'd0, 16'h0001, 32'd0}, 5, 2, 17'h10000);
        tbl[2] = mk(1'b0, 4'b0100, {16'd0, 16'hFFFF, 32'd0}, {16'd0, 16'hFFFF, 32'd0}, 0, 2, 17'h1FFFE);
        tbl[3] = mk(1'b1, 4'hF, va, vb, 0, 0, 17'd300);
        tbl[4] = mk(1'b0, 4'hF, va, vb, 0, 1, 17'h10000);
        tbl[5] = mk(1'b0, 4'hF, va, vb, 0, 2, 17'd5555);
        tbl[6] = mk(1'b0, 4'hF, va, vb, 0, 3, 17'h10010);
        tbl[7] = mk(1'b0, 4'hF, va, vb, 0, 0, 17'd300);

        // Reset state
        do_reset();
        #1;
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset rsp_sum", 32'(bus.rsp_sum), 32'd0);
        chk("reset rsp_carry", 32'(bus.rsp_carry), 32'd0);
        chk("reset rsp_id", 32'(bus.rsp_id), 32'd0);
        @(negedge clk);
        chk("idle no req valid", 32'(bus.rsp_valid), 32'd0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].rst) do_reset();
            txn(tbl[i].mask, tbl[i].a, tbl[i].b, tbl[i].stall, tbl[i].exp_id,
                tbl[i].exp_res, $sformatf("vec%0d", i));
        end

        // Reset while EXEC: no response, pointer back to N-1
        do_reset();
        ra = '0; rb = '0;
        ra[1] = 16'd5; rb[1] = 16'd6;
        bus.req_valid = 4'b0010;
        bus.req_a = ra;
        bus.req_b = rb;
        bus.rsp_ready = 1'b1;
        #1;
        chk("abort grant", 32'(bus.req_ready), 32'b0010);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_last = N - 1;
        for (int k = 0; k < 3; k++) begin
            chk("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("abort rsp_sum", 32'(bus.rsp_sum), 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        ra[3] = 16'd9; rb[3] = 16'd10;
        txn(4'b1010, ra, rb, 0, 1, 17'd11, "after abort");

        // Sweep through requester 1
        for (int i = 0; i < 2500; i++) begin
            bb = (i * 1237) % 2500;
            ra = '0; rb = '0;
            ra[1] = 16'(i); rb[1] = 16'(bb);
            txn(4'b0010, ra, rb, 0, 1, 17'(i + bb), "sweep");
        end

        // Random traffic against the round-robin model
        for (int i = 0; i < 400; i++) begin
            m = 4'($urandom_range(0, 15));
            if (m == 4'd0) begin
                bus.req_valid = '0;
                #1;
                chk("rand idle ready", 32'(bus.req_ready), 32'd0);
                @(negedge clk);
                chk("rand idle valid", 32'(bus.rsp_valid), 32'd0);
            end else begin
                for (int k = 0; k < N; k++) begin
                    ra[k] = 16'($urandom);
                    rb[k] = 16'($urandom);
                end
                if (i % 7 == 0) begin
                    ra[0] = 16'hFFFF; rb[0] = 16'hFFFF;
                end
                pick = model_pick(m, model_last);
                txn(m, ra, rb, int'($urandom_range(0, 2)), pick,
                    {1'b0, ra[pick]} + {1'b0, rb[pick]}, "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
